chase_tp_scheduler: RTL and testbench
=====================================

Name: chase_tp_scheduler

Overview:
- Sequences test-pattern (TP) passes through the syndrome switch and the downstream key-equation/Chien decoder for one codeword.
- Issues single-cycle next-TP pulses to the switch and collects per-TP correlation metrics from the decoder.
- Selects the best TP, the one with the minimum metric, and signals frame completion or a timeout error.
- Sits between the top-level controller and the syndrome switch/decoder pair.

Parameters:
- METRIC_W, 12, width of the per-TP correlation metric.
- TIMEOUT_CYC, 1023, maximum cycles spent waiting for syndrome-valid or decoder-done before aborting the frame.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  frame start pulse; mode and code are sampled on this cycle
- i_mode  in  1  0 = hard decision (one TP); 1 = soft/Chase (four TPs)
- i_code  in  2  2'b10 = one full TP per pass; 2'b00/2'b01 = two TPs per pass (pair)
- i_syn_valid  in  1  syndrome-valid pulse from the syndrome switch output
- i_dec_done  in  1  decoder finished the current pass (one-cycle pulse)
- i_dec_metric_lo  in  METRIC_W  metric of the first TP in the pass; valid with i_dec_done
- i_dec_metric_hi  in  METRIC_W  metric of the second TP in the pass; used only in paired passes
- o_next_tp  out  1  single-cycle pulse that advances the syndrome switch to the next pass
- o_pass_idx  out  2  index of the current pass
- o_busy  out  1  high from the cycle after an accepted i_start until the cycle o_done is asserted
- o_done  out  1  single-cycle frame-complete pulse
- o_err  out  1  timeout flag; valid with o_done and held until the next start
- o_best_idx  out  2  winning TP index, 0..3; held until the next start
- o_best_metric  out  METRIC_W  winning metric; held until the next start

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset is asynchronous; asserting it mid-frame aborts immediately with no o_done.
- Pass count N is latched at i_start:
  - i_mode=0: N=1.
  - i_mode=1 and code=2'b10: N=4.
  - i_mode=1 and any other code: N=2.
- States:
  - IDLE: on i_start go to WAIT_SYN; clear the pass index, timer and o_err; set the best metric to all-ones. i_start is ignored in every other state.
  - WAIT_SYN: wait for i_syn_valid, then go to WAIT_DEC and clear the timer.
  - WAIT_DEC: wait for i_dec_done. In that cycle, evaluate the candidates:
    - Full or single passes: one candidate, metric_lo, with TP index = pass_idx.
    - Paired passes: two candidates, metric_lo with index 2*pass_idx and metric_hi with index 2*pass_idx+1.
    - A candidate replaces the best only if strictly less than it. Ties keep the lower index; lo is evaluated before hi.
    - If pass_idx == N-1, go to DONE; otherwise go to ISSUE.
  - ISSUE: assert o_next_tp for exactly one cycle, increment pass_idx, go to WAIT_SYN.
  - DONE: assert o_done for one cycle, deassert o_busy the same cycle, return to IDLE.
- All outputs are registered.
- o_next_tp rises 2 cycles after the i_dec_done cycle: the WAIT_DEC→ISSUE register, then the output register.
- o_done rises 2 cycles after the final i_dec_done.
- Timer: a saturating counter runs in WAIT_SYN and WAIT_DEC. When it reaches TIMEOUT_CYC, go to DONE with o_err=1; the best outputs keep whatever has been collected so far.
- Simultaneous events:
  - i_syn_valid and timer expiry in the same cycle: the valid wins.
  - i_dec_done and timer expiry in the same cycle: done wins.
- i_dec_done outside WAIT_DEC is ignored. i_syn_valid outside WAIT_SYN is ignored.
- pass_idx never exceeds N-1. No o_next_tp is issued after the last pass.
- Metric width: comparisons are unsigned, METRIC_W bits. The all-ones initial value means a real all-ones metric still wins, because it ties and index 0 is evaluated first.

Test Plan:
- Hard mode: i_start with mode=0; syn_valid; dec_done with lo=5 → no o_next_tp; o_done 2 cycles later; best_idx=0, best_metric=5, err=0.
- Full Chase, code=2'b10: metrics 9, 3, 7, 3 over 4 passes → exactly 3 o_next_tp pulses, pass_idx 0→3; best_idx=1, best_metric=3 (tie at TP3 rejected).
- Paired Chase, code=2'b00: pass 0 lo=8/hi=4, pass 1 lo=4/hi=2 → exactly 1 o_next_tp; best_idx=3, best_metric=2.
- Timeout with TIMEOUT_CYC=15: start, syn_valid never arrives → o_done at cycle 16-17 after start with err=1 and best_metric all-ones.
- Robustness: i_start repeated while busy, plus stray dec_done in WAIT_SYN → both ignored, result unchanged.
- Reset mid-operation: rst_n low mid-WAIT_DEC → outputs 0 immediately; a following frame runs cleanly.

Source files
------------

// File: rtl/chase_tp_scheduler.sv
// Chase test-pattern pass sequencer: steps the syndrome switch, tracks the minimum decoder metric.
// o_next_tp / o_done rise two cycles after i_dec_done; no backpressure, events outside their wait state are dropped.
module chase_tp_scheduler #(
   parameter int METRIC_W    = 12,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic                i_mode,
   input  logic [1:0]          i_code,
   input  logic                i_syn_valid,
   input  logic                i_dec_done,
   input  logic [METRIC_W-1:0] i_dec_metric_lo,
   input  logic [METRIC_W-1:0] i_dec_metric_hi,
   output logic                o_next_tp,
   output logic [1:0]          o_pass_idx,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err,
   output logic [1:0]          o_best_idx,
   output logic [METRIC_W-1:0] o_best_metric
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_SYN = 3'd1;
   localparam logic [2:0] S_WAIT_DEC = 3'd2;
   localparam logic [2:0] S_ISSUE    = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [1:0]          pass_idx_q, pass_idx_d;
   logic [1:0]          last_idx_q, last_idx_d;
   logic                paired_q, paired_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                next_tp_q, next_tp_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [1:0]          best_idx_q, best_idx_d;
   logic [METRIC_W-1:0] best_metric_q, best_metric_d;

   logic [1:0]          lo_idx, hi_idx, cand_idx1, cand_idx2;
   logic [METRIC_W-1:0] cand_m1, cand_m2;

   // lo is folded in before hi so equal metrics keep the lower TP index.
   always_comb begin
      lo_idx    = paired_q ? {pass_idx_q[0], 1'b0} : pass_idx_q;
      hi_idx    = {pass_idx_q[0], 1'b1};
      cand_m1   = best_metric_q;
      cand_idx1 = best_idx_q;
      if (i_dec_metric_lo < best_metric_q) begin
         cand_m1   = i_dec_metric_lo;
         cand_idx1 = lo_idx;
      end
      cand_m2   = cand_m1;
      cand_idx2 = cand_idx1;
      if (paired_q && (i_dec_metric_hi < cand_m1)) begin
         cand_m2   = i_dec_metric_hi;
         cand_idx2 = hi_idx;
      end
   end

   always_comb begin
      state_d       = state_q;
      pass_idx_d    = pass_idx_q;
      last_idx_d    = last_idx_q;
      paired_d      = paired_q;
      timer_d       = timer_q;
      next_tp_d     = 1'b0;
      busy_d        = busy_q;
      done_d        = 1'b0;
      err_d         = err_q;
      best_idx_d    = best_idx_q;
      best_metric_d = best_metric_q;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d       = S_WAIT_SYN;
               pass_idx_d    = 2'd0;
               timer_d       = '0;
               err_d         = 1'b0;
               busy_d        = 1'b1;
               best_idx_d    = 2'd0;
               best_metric_d = '1;
               paired_d      = i_mode && (i_code != 2'b10);
               if (!i_mode)               last_idx_d = 2'd0;
               else if (i_code == 2'b10)  last_idx_d = 2'd3;
               else                       last_idx_d = 2'd1;
            end
         end
         S_WAIT_SYN: begin
            if (i_syn_valid) begin
               state_d = S_WAIT_DEC;
               timer_d = '0;
            end else if (timer_q == TMR_MAX) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_WAIT_DEC: begin
            if (i_dec_done) begin
               best_metric_d = cand_m2;
               best_idx_d    = cand_idx2;
               timer_d       = '0;
               state_d       = (pass_idx_q == last_idx_q) ? S_DONE : S_ISSUE;
            end else if (timer_q == TMR_MAX) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_ISSUE: begin
            next_tp_d  = 1'b1;
            pass_idx_d = pass_idx_q + 2'd1;
            timer_d    = '0;
            state_d    = S_WAIT_SYN;
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= S_IDLE;
         pass_idx_q    <= 2'd0;
         last_idx_q    <= 2'd0;
         paired_q      <= 1'b0;
         timer_q       <= '0;
         next_tp_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         best_idx_q    <= 2'd0;
         best_metric_q <= '0;
      end else begin
         state_q       <= state_d;
         pass_idx_q    <= pass_idx_d;
         last_idx_q    <= last_idx_d;
         paired_q      <= paired_d;
         timer_q       <= timer_d;
         next_tp_q     <= next_tp_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
         best_idx_q    <= best_idx_d;
         best_metric_q <= best_metric_d;
      end
   end

   assign o_next_tp     = next_tp_q;
   assign o_pass_idx    = pass_idx_q;
   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_err         = err_q;
   assign o_best_idx    = best_idx_q;
   assign o_best_metric = best_metric_q;

endmodule

// File: tb/tb_chase_tp_scheduler.sv
// Bench for chase_tp_scheduler: directed plan frames, timeouts, reset abort, then random frames vs. a TP-level model.
module tb_chase_tp_scheduler;
   localparam int MW = 12;
   localparam int TO = 15;

   typedef logic [MW-1:0] tp_arr_t [4];

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_start, i_mode, i_syn_valid, i_dec_done;
   logic [1:0]    i_code;
   logic [MW-1:0] i_dec_metric_lo, i_dec_metric_hi;
   logic          o_next_tp, o_busy, o_done, o_err;
   logic [1:0]    o_pass_idx, o_best_idx;
   logic [MW-1:0] o_best_metric;

   int checks = 0;
   int failures = 0;
   int ntp_cnt = 0;
   int done_cnt = 0;

   always #5 i_clk = ~i_clk;

   chase_tp_scheduler #(.METRIC_W(MW), .TIMEOUT_CYC(TO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode), .i_code(i_code),
      .i_syn_valid(i_syn_valid), .i_dec_done(i_dec_done),
      .i_dec_metric_lo(i_dec_metric_lo), .i_dec_metric_hi(i_dec_metric_hi),
      .o_next_tp(o_next_tp), .o_pass_idx(o_pass_idx), .o_busy(o_busy), .o_done(o_done),
      .o_err(o_err), .o_best_idx(o_best_idx), .o_best_metric(o_best_metric)
   );

   always @(negedge i_clk) begin
      if (o_next_tp) ntp_cnt <= ntp_cnt + 1;
      if (o_done)    done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Model at the TP level: a Chase frame has four TPs, a hard frame one; lowest metric wins, ties to lowest index.
   function automatic void ref_frame(input logic mode, input logic [1:0] code, input tp_arr_t tp,
                                     output int n_pass, output logic [1:0] bidx, output logic [MW-1:0] bm);
      int ntp;
      ntp    = mode ? 4 : 1;
      n_pass = !mode ? 1 : ((code == 2'b10) ? 4 : 2);
      bm     = '1;
      bidx   = 2'd0;
      for (int i = 0; i < ntp; i++) begin
         if (tp[i] < bm) begin
            bm   = tp[i];
            bidx = 2'(i);
         end
      end
   endfunction

   task automatic run_frame(input string name, input logic mode, input logic [1:0] code, input tp_arr_t tp,
                            input int syn_d, input int dec_d, input bit stray);
      int n_pass, ntp0, dn0, sd, dd;
      logic [1:0] bidx;
      logic [MW-1:0] bm;
      bit paired;
      ref_frame(mode, code, tp, n_pass, bidx, bm);
      paired = mode && (code != 2'b10);
      ntp0 = ntp_cnt;
      dn0  = done_cnt;
      i_start = 1'b1; i_mode = mode; i_code = code;
      tick();
      i_start = 1'b0; i_mode = 1'($urandom); i_code = 2'($urandom);
      chk({name, "/busy_after_start"}, 32'(o_busy), 32'd1);
      for (int p = 0; p < n_pass; p++) begin
         sd = (syn_d < 0) ? $urandom_range(0, 4) : syn_d;
         if (stray && sd == 0) sd = 2;
         repeat (sd) begin
            if (stray) begin
               i_start = 1'b1; i_mode = 1'b0; i_dec_done = 1'b1;
               i_dec_metric_lo = '0; i_dec_metric_hi = '0;
            end
            tick();
         end
         i_start = 1'b0; i_dec_done = 1'b0;
         i_syn_valid = 1'b1;
         tick();
         i_syn_valid = 1'b0;
         dd = (dec_d < 0) ? $urandom_range(0, 4) : dec_d;
         repeat (dd) tick();
         i_dec_metric_lo = paired ? tp[2*p] : tp[p];
         i_dec_metric_hi = paired ? tp[2*p+1] : MW'($urandom);
         i_dec_done = 1'b1;
         tick();
         i_dec_done = 1'b0;
         i_dec_metric_lo = MW'($urandom); i_dec_metric_hi = MW'($urandom);
         chk({name, "/no_pulse_1cyc_after_dec"}, 32'(o_next_tp | o_done), 32'd0);
         tick();
         if (p < n_pass - 1) begin
            chk({name, "/next_tp_2cyc_after_dec"}, 32'(o_next_tp), 32'd1);
            chk({name, "/pass_idx"}, 32'(o_pass_idx), 32'(p + 1));
         end else begin
            chk({name, "/done_2cyc_after_dec"}, 32'(o_done), 32'd1);
            chk({name, "/busy_low_with_done"}, 32'(o_busy), 32'd0);
         end
      end
      chk({name, "/err"}, 32'(o_err), 32'd0);
      chk({name, "/best_idx"}, 32'(o_best_idx), 32'(bidx));
      chk({name, "/best_metric"}, 32'(o_best_metric), 32'(bm));
      chk({name, "/final_pass_idx"}, 32'(o_pass_idx), 32'(n_pass - 1));
      tick();
      chk({name, "/done_single_cycle"}, 32'(o_done), 32'd0);
      chk({name, "/next_tp_count"}, 32'(ntp_cnt - ntp0), 32'(n_pass - 1));
      chk({name, "/done_count"}, 32'(done_cnt - dn0), 32'd1);
   endtask

   task automatic wait_done(input string name, output int k);
      k = 0;
      while (k < 40) begin
         tick();
         k++;
         if (o_done) break;
      end
      if (!o_done) begin
         checks++;
         failures++;
         $error("FAIL %s/done_timeout observed=no_done expected=done", name);
      end
   endtask

   initial begin
      tp_arr_t t;
      int k, dn0;
      logic m;
      logic [1:0] c;

      i_rst_n = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_code = 2'b00;
      i_syn_valid = 1'b0; i_dec_done = 1'b0; i_dec_metric_lo = '0; i_dec_metric_hi = '0;
      #12;
      chk("reset/busy", 32'(o_busy), 32'd0);
      chk("reset/done", 32'(o_done), 32'd0);
      chk("reset/next_tp", 32'(o_next_tp), 32'd0);
      chk("reset/err", 32'(o_err), 32'd0);
      chk("reset/pass_idx", 32'(o_pass_idx), 32'd0);
      chk("reset/best_idx", 32'(o_best_idx), 32'd0);
      chk("reset/best_metric", 32'(o_best_metric), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick();

      t = '{12'd5, 12'd0, 12'd0, 12'd0};
      run_frame("hard", 1'b0, 2'b00, t, -1, -1, 1'b0);
      t = '{12'd9, 12'd3, 12'd7, 12'd3};
      run_frame("full", 1'b1, 2'b10, t, -1, -1, 1'b0);
      t = '{12'd8, 12'd4, 12'd4, 12'd2};
      run_frame("paired", 1'b1, 2'b00, t, -1, -1, 1'b0);
      t = '{12'd9, 12'd3, 12'd7, 12'd3};
      run_frame("stray", 1'b1, 2'b10, t, -1, -1, 1'b1);
      t = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
      run_frame("all_ones", 1'b1, 2'b01, t, -1, -1, 1'b0);
      t = '{12'd7, 12'd0, 12'd0, 12'd0};
      run_frame("syn_vs_timeout", 1'b0, 2'b00, t, TO, 0, 1'b0);
      t = '{12'd4, 12'd0, 12'd0, 12'd0};
      run_frame("dec_vs_timeout", 1'b0, 2'b00, t, 0, TO, 1'b0);

      // Syndrome never arrives.
      dn0 = done_cnt;
      i_start = 1'b1; i_mode = 1'b1; i_code = 2'b10;
      tick();
      i_start = 1'b0;
      wait_done("to_syn", k);
      chk("to_syn/latency", 32'(k), 32'(TO + 2));
      chk("to_syn/err", 32'(o_err), 32'd1);
      chk("to_syn/best_metric", 32'(o_best_metric), 32'hFFF);
      chk("to_syn/best_idx", 32'(o_best_idx), 32'd0);
      chk("to_syn/busy", 32'(o_busy), 32'd0);
      tick();
      chk("to_syn/err_held", 32'(o_err), 32'd1);
      chk("to_syn/done_count", 32'(done_cnt - dn0), 32'd1);

      // Decoder hangs on the second pass; the first pass result is kept.
      i_start = 1'b1; i_mode = 1'b1; i_code = 2'b10;
      tick();
      i_start = 1'b0;
      i_syn_valid = 1'b1; tick(); i_syn_valid = 1'b0;
      i_dec_metric_lo = 12'd6; i_dec_done = 1'b1; tick(); i_dec_done = 1'b0;
      tick();
      chk("to_dec/next_tp", 32'(o_next_tp), 32'd1);
      i_syn_valid = 1'b1; tick(); i_syn_valid = 1'b0;
      wait_done("to_dec", k);
      chk("to_dec/latency", 32'(k), 32'(TO + 2));
      chk("to_dec/err", 32'(o_err), 32'd1);
      chk("to_dec/best_metric", 32'(o_best_metric), 32'd6);
      chk("to_dec/pass_idx", 32'(o_pass_idx), 32'd1);
      tick();

      // Reset mid-WAIT_DEC on the second pass.
      i_start = 1'b1; i_mode = 1'b1; i_code = 2'b10;
      tick();
      i_start = 1'b0;
      i_syn_valid = 1'b1; tick(); i_syn_valid = 1'b0;
      i_dec_metric_lo = 12'd3; i_dec_done = 1'b1; tick(); i_dec_done = 1'b0;
      tick();
      i_syn_valid = 1'b1; tick(); i_syn_valid = 1'b0;
      chk("rst/pre_pass_idx", 32'(o_pass_idx), 32'd1);
      dn0 = done_cnt;
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("rst/busy", 32'(o_busy), 32'd0);
      chk("rst/pass_idx", 32'(o_pass_idx), 32'd0);
      chk("rst/best_metric", 32'(o_best_metric), 32'd0);
      chk("rst/err", 32'(o_err), 32'd0);
      repeat (3) tick();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick();
      chk("rst/no_done", 32'(done_cnt - dn0), 32'd0);
      t = '{12'd11, 12'd10, 12'd12, 12'd1};
      run_frame("after_rst", 1'b1, 2'b01, t, -1, -1, 1'b0);

      for (int r = 0; r < 20; r++) begin
         m = 1'($urandom);
         c = 2'($urandom);
         for (int i = 0; i < 4; i++) t[i] = ($urandom_range(0, 7) == 0) ? 12'hFFF : MW'($urandom_range(0, 15));
         run_frame($sformatf("rand%0d", r), m, c, t, -1, -1, 1'($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
